// File: rtl/hack_ram_loader.sv
// hack_ram_loader: boot loader that streams a UART byte image into the 32K x 16 RAM
// and holds the CPU in reset until the image is written.
// Stream: 16-bit word count N (high byte first), then N 16-bit data words.
// Optional feature macro: HACK_RAM_LOADER_CHECKSUM_EN appends a 16-bit checksum word
// (sum mod 2^16 of the data words) that must match for the load to succeed.
module hack_ram_loader #(
  parameter int unsigned ADDR_W         = 15,
  parameter int unsigned BASE_ADDR      = 0,
  parameter int unsigned MAX_WORDS      = 32768,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [15:0]       ram_in,
  output logic              ram_load,
  output logic [ADDR_W-1:0] ram_address,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       words_written
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_CSUM_HI,
    S_CSUM_LO,
    S_DONE,
    S_ERROR
  } state_t;

`ifdef HACK_RAM_LOADER_CHECKSUM_EN
  localparam state_t S_AFTER_DATA = S_CSUM_HI;
`else
  localparam state_t S_AFTER_DATA = S_DONE;
`endif

  state_t state, state_d;

  logic [7:0]        hi_q, hi_d;
  logic [15:0]       len_q, len_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [15:0]       ww_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [15:0]       ram_in_d;
  logic              ram_load_d;
  logic [ADDR_W-1:0] ram_address_d;
  logic              cpu_reset_d;
  logic              busy_d;
  logic              done_d;
  logic              error_d;
`ifdef HACK_RAM_LOADER_CHECKSUM_EN
  logic [15:0]       csum_q, csum_d;
`endif

  logic [15:0] rx_word;
  logic [15:0] ww_inc;
  logic        active;

  assign rx_word = {hi_q, rx_data};
  assign ww_inc  = words_written + 16'd1;
  assign active  = (state == S_LEN_HI) || (state == S_LEN_LO) || (state == S_DATA_HI) ||
                   (state == S_DATA_LO) || (state == S_CSUM_HI) || (state == S_CSUM_LO);

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_d;
  end

  // Next-state logic: byte-driven transitions plus the inter-byte timeout
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: if (start) state_d = S_LEN_HI;
      S_LEN_HI:  if (rx_valid) state_d = S_LEN_LO;
      S_LEN_LO: begin
        if (rx_valid) begin
          if (32'(rx_word) > MAX_WORDS) state_d = S_ERROR;
          else if (rx_word == 16'd0)    state_d = S_AFTER_DATA;
          else                          state_d = S_DATA_HI;
        end
      end
      S_DATA_HI: if (rx_valid) state_d = S_DATA_LO;
      S_DATA_LO: begin
        if (rx_valid) state_d = (ww_inc == len_q) ? S_AFTER_DATA : S_DATA_HI;
      end
`ifdef HACK_RAM_LOADER_CHECKSUM_EN
      S_CSUM_HI: if (rx_valid) state_d = S_CSUM_LO;
      S_CSUM_LO: if (rx_valid) state_d = (rx_word == csum_q) ? S_DONE : S_ERROR;
`endif
      default: state_d = S_IDLE;
    endcase
    if (active && !rx_valid && (tmo_q == TMO_LAST)) state_d = S_ERROR;
  end

  // Output/datapath logic: next values for every registered output and counter
  always_comb begin
    hi_d          = hi_q;
    len_d         = len_q;
    ptr_d         = ptr_q;
    ww_d          = words_written;
    ram_in_d      = ram_in;
    ram_address_d = ram_address;
    ram_load_d    = 1'b0;
`ifdef HACK_RAM_LOADER_CHECKSUM_EN
    csum_d        = csum_q;
`endif
    if (active) tmo_d = rx_valid ? '0 : tmo_q + TMO_W'(1);
    else        tmo_d = '0;

    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          ww_d  = 16'd0;
          ptr_d = BASE;
          len_d = 16'd0;
`ifdef HACK_RAM_LOADER_CHECKSUM_EN
          csum_d = 16'd0;
`endif
        end
      end
      S_LEN_HI:  if (rx_valid) hi_d = rx_data;
      S_LEN_LO:  if (rx_valid) len_d = rx_word;
      S_DATA_HI: if (rx_valid) hi_d = rx_data;
      S_DATA_LO: begin
        if (rx_valid) begin
          ram_in_d      = rx_word;
          ram_address_d = ptr_q;
          ram_load_d    = 1'b1;
          ptr_d         = ptr_q + ADDR_W'(1);
          ww_d          = ww_inc;
`ifdef HACK_RAM_LOADER_CHECKSUM_EN
          csum_d        = csum_q + rx_word;
`endif
        end
      end
`ifdef HACK_RAM_LOADER_CHECKSUM_EN
      S_CSUM_HI: if (rx_valid) hi_d = rx_data;
`endif
      default: ;
    endcase

    busy_d      = (state_d != S_IDLE) && (state_d != S_DONE) && (state_d != S_ERROR);
    done_d      = (state_d == S_DONE);
    error_d     = (state_d == S_ERROR);
    // CPU released only once DONE has been held for a cycle, i.e. after the last strobe
    cpu_reset_d = !((state == S_DONE) && (state_d == S_DONE));
  end

  // Datapath and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hi_q          <= 8'd0;
      len_q         <= 16'd0;
      ptr_q         <= BASE;
      tmo_q         <= '0;
      words_written <= 16'd0;
      ram_in        <= 16'd0;
      ram_load      <= 1'b0;
      ram_address   <= BASE;
      cpu_reset     <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
`ifdef HACK_RAM_LOADER_CHECKSUM_EN
      csum_q        <= 16'd0;
`endif
    end else begin
      hi_q          <= hi_d;
      len_q         <= len_d;
      ptr_q         <= ptr_d;
      tmo_q         <= tmo_d;
      words_written <= ww_d;
      ram_in        <= ram_in_d;
      ram_load      <= ram_load_d;
      ram_address   <= ram_address_d;
      cpu_reset     <= cpu_reset_d;
      busy          <= busy_d;
      done          <= done_d;
      error         <= error_d;
`ifdef HACK_RAM_LOADER_CHECKSUM_EN
      csum_q        <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_hack_ram_loader.sv
// tb_hack_ram_loader: directed bench for hack_ram_loader. Three instances cover the
// default configuration, a top-of-RAM base address (wrap) and a short timeout.
module tb_hack_ram_loader;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;

  logic [15:0] d0_ram_in, d1_ram_in, d2_ram_in;
  logic        d0_ram_load, d1_ram_load, d2_ram_load;
  logic [14:0] d0_ram_address, d1_ram_address, d2_ram_address;
  logic        d0_cpu_reset, d1_cpu_reset, d2_cpu_reset;
  logic        d0_busy, d1_busy, d2_busy;
  logic        d0_done, d1_done, d2_done;
  logic        d0_error, d1_error, d2_error;
  logic [15:0] d0_ww, d1_ww, d2_ww;

  int errors = 0;
  int checks = 0;
  int consec = 0;
  logic prev0 = 1'b0, prev1 = 1'b0, prev2 = 1'b0;
  logic [31:0] log0[$];
  logic [31:0] log1[$];
  logic [31:0] log2[$];

  always #5 clock = ~clock;

  hack_ram_loader u_dut (
    .clock(clock), .reset_n(reset_n), .start(start0), .rx_data(rx_data), .rx_valid(rx_valid),
    .ram_in(d0_ram_in), .ram_load(d0_ram_load), .ram_address(d0_ram_address),
    .cpu_reset(d0_cpu_reset), .busy(d0_busy), .done(d0_done), .error(d0_error),
    .words_written(d0_ww)
  );

  hack_ram_loader #(.BASE_ADDR(32767)) u_wrap (
    .clock(clock), .reset_n(reset_n), .start(start1), .rx_data(rx_data), .rx_valid(rx_valid),
    .ram_in(d1_ram_in), .ram_load(d1_ram_load), .ram_address(d1_ram_address),
    .cpu_reset(d1_cpu_reset), .busy(d1_busy), .done(d1_done), .error(d1_error),
    .words_written(d1_ww)
  );

  hack_ram_loader #(.TIMEOUT_CYCLES(16)) u_tmo (
    .clock(clock), .reset_n(reset_n), .start(start2), .rx_data(rx_data), .rx_valid(rx_valid),
    .ram_in(d2_ram_in), .ram_load(d2_ram_load), .ram_address(d2_ram_address),
    .cpu_reset(d2_cpu_reset), .busy(d2_busy), .done(d2_done), .error(d2_error),
    .words_written(d2_ww)
  );

  // Record every write strobe as {address, data} and flag back-to-back strobes
  always @(negedge clock) begin
    if (d0_ram_load) log0.push_back({1'b0, d0_ram_address, d0_ram_in});
    if (d1_ram_load) log1.push_back({1'b0, d1_ram_address, d1_ram_in});
    if (d2_ram_load) log2.push_back({1'b0, d2_ram_address, d2_ram_in});
    if ((d0_ram_load && prev0) || (d1_ram_load && prev1) || (d2_ram_load && prev2)) consec++;
    prev0 = d0_ram_load;
    prev1 = d1_ram_load;
    prev2 = d2_ram_load;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clock);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clock);
    rx_valid = 1'b0;
  endtask

  // Start pulse carries a junk byte that must be ignored
  task automatic pulse_start(input int which);
    @(negedge clock);
    if (which == 0) start0 = 1'b1;
    if (which == 1) start1 = 1'b1;
    if (which == 2) start2 = 1'b1;
    rx_data  = 8'hFF;
    rx_valid = 1'b1;
    @(negedge clock);
    start0   = 1'b0;
    start1   = 1'b0;
    start2   = 1'b0;
    rx_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("rst_load",   32'(d0_ram_load), 32'd0);
    check("rst_cpurst", 32'(d0_cpu_reset), 32'd1);
    check("rst_done",   32'(d0_done), 32'd0);
    check("rst_error",  32'(d0_error), 32'd0);
    check("rst_busy",   32'(d0_busy), 32'd0);
    check("rst_addr",   32'(d0_ram_address), 32'd0);
    check("rst_ww",     32'(d0_ww), 32'd0);
    check("rst_addr_base", 32'(d1_ram_address), 32'h7FFF);

    // Basic two-word load
    pulse_start(0);
    check("basic_busy", 32'(d0_busy), 32'd1);
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h12); send_byte(8'h34);
    send_byte(8'hAB); send_byte(8'hCD);
    check("basic_done_now", 32'(d0_done), 32'd1);
    check("basic_cpurst_now", 32'(d0_cpu_reset), 32'd1);
    @(negedge clock);
    check("basic_done", 32'(d0_done), 32'd1);
    check("basic_cpurst", 32'(d0_cpu_reset), 32'd0);
    check("basic_ww", 32'(d0_ww), 32'd2);
    check("basic_busy_end", 32'(d0_busy), 32'd0);
    check("basic_nwrites", 32'(log0.size()), 32'd2);
    check("basic_w0", log0.size() > 0 ? log0[0] : 32'hDEAD, 32'h0000_1234);
    check("basic_w1", log0.size() > 1 ? log0[1] : 32'hDEAD, 32'h0001_ABCD);
    check("basic_hold_addr", 32'(d0_ram_address), 32'd1);
    check("basic_hold_data", 32'(d0_ram_in), 32'hABCD);
    log0.delete();

    // Zero-length image
    pulse_start(0);
    send_byte(8'h00); send_byte(8'h00);
`ifdef HACK_RAM_LOADER_CHECKSUM_EN
    send_byte(8'h00); send_byte(8'h00);
`endif
    @(negedge clock);
    check("zero_done", 32'(d0_done), 32'd1);
    check("zero_error", 32'(d0_error), 32'd0);
    check("zero_ww", 32'(d0_ww), 32'd0);
    check("zero_nwrites", 32'(log0.size()), 32'd0);
`ifdef HACK_RAM_LOADER_CHECKSUM_EN
    pulse_start(0);
    send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h00); send_byte(8'h01);
    @(negedge clock);
    check("zero_badsum_err", 32'(d0_error), 32'd1);
    check("zero_badsum_done", 32'(d0_done), 32'd0);
`endif

    // Over-length count
    pulse_start(0);
    send_byte(8'h80); send_byte(8'h01);
    check("len_error", 32'(d0_error), 32'd1);
    check("len_busy", 32'(d0_busy), 32'd0);
    check("len_cpurst", 32'(d0_cpu_reset), 32'd1);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    check("len_nwrites", 32'(log0.size()), 32'd0);
    check("len_error_hold", 32'(d0_error), 32'd1);
    check("len_cpurst_hold", 32'(d0_cpu_reset), 32'd1);

    // Address wrap at top of RAM
    pulse_start(1);
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h00); send_byte(8'h02);
`ifdef HACK_RAM_LOADER_CHECKSUM_EN
    send_byte(8'h00); send_byte(8'h03);
`endif
    @(negedge clock);
    check("wrap_done", 32'(d1_done), 32'd1);
    check("wrap_nwrites", 32'(log1.size()), 32'd2);
    check("wrap_w0", log1.size() > 0 ? log1[0] : 32'hDEAD, 32'h7FFF_0001);
    check("wrap_w1", log1.size() > 1 ? log1[1] : 32'hDEAD, 32'h0000_0002);

    // Timeout after one of three words
    pulse_start(2);
    send_byte(8'h00); send_byte(8'h03);
    send_byte(8'h11); send_byte(8'h22);
    repeat (15) @(negedge clock);
    check("tmo_err_early", 32'(d2_error), 32'd0);
    check("tmo_busy_early", 32'(d2_busy), 32'd1);
    @(negedge clock);
    check("tmo_error", 32'(d2_error), 32'd1);
    check("tmo_busy", 32'(d2_busy), 32'd0);
    check("tmo_cpurst", 32'(d2_cpu_reset), 32'd1);
    check("tmo_nwrites", 32'(log2.size()), 32'd1);
    check("tmo_w0", log2.size() > 0 ? log2[0] : 32'hDEAD, 32'h0000_1122);

    // Reset pulse mid-load, then a clean reload
    log0.delete();
    pulse_start(0);
    send_byte(8'h00); send_byte(8'h03);
    send_byte(8'h12); send_byte(8'h34);
    check("mid_busy", 32'(d0_busy), 32'd1);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("mid_rst_load", 32'(d0_ram_load), 32'd0);
    check("mid_rst_cpurst", 32'(d0_cpu_reset), 32'd1);
    check("mid_rst_busy", 32'(d0_busy), 32'd0);
    check("mid_rst_done_err", {30'd0, d0_done, d0_error}, 32'd0);
    check("mid_rst_addr", 32'(d0_ram_address), 32'd0);
    check("mid_rst_data", 32'(d0_ram_in), 32'd0);
    check("mid_rst_ww", 32'(d0_ww), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    pulse_start(0);
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h00); send_byte(8'h02);
`ifdef HACK_RAM_LOADER_CHECKSUM_EN
    send_byte(8'h00); send_byte(8'h03);
`endif
    @(negedge clock);
    check("reload_done", 32'(d0_done), 32'd1);
    check("reload_cpurst", 32'(d0_cpu_reset), 32'd0);
    check("reload_ww", 32'(d0_ww), 32'd2);
    check("reload_nwrites", 32'(log0.size()), 32'd3);
    check("reload_w1", log0.size() > 1 ? log0[1] : 32'hDEAD, 32'h0000_0001);
    check("reload_w2", log0.size() > 2 ? log0[2] : 32'hDEAD, 32'h0001_0002);
`ifdef HACK_RAM_LOADER_CHECKSUM_EN
    pulse_start(0);
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h00); send_byte(8'h04);
    @(negedge clock);
    check("badsum_error", 32'(d0_error), 32'd1);
    check("badsum_cpurst", 32'(d0_cpu_reset), 32'd1);
`endif

    check("no_back_to_back_load", 32'(consec), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hack_ram_loader.md
Name: hack_ram_loader

Overview:
- Boot loader stage directly upstream of the 32K x 16 data/program RAM. Drives the RAM's `in`/`load`/`address` port.
- Consumes a byte stream from the UART receiver, assembles 16-bit words (high byte first) and writes them to consecutive RAM addresses.
- Holds the CPU in reset until the image is fully written.
- Stream format: 16-bit word count N, then N data words. With the optional feature, a 16-bit checksum word follows.

Parameters:
- ADDR_W, 15, RAM address width. Addresses wrap modulo 2^ADDR_W.
- BASE_ADDR, 0, RAM address of the first data word.
- MAX_WORDS, 32768, largest legal N. Any larger N is a length error.
- TIMEOUT_CYCLES, 1000000, idle cycles allowed between bytes mid-transfer before a timeout error. Counter width is clog2(TIMEOUT_CYCLES+1).

Ports:
- clock  input  1  system clock; all logic on the rising edge
- reset_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle request to begin a load; only accepted in IDLE, DONE or ERROR
- rx_data  input  8  received byte
- rx_valid  input  1  rx_data valid for this cycle; one byte per high cycle; no backpressure
- ram_in  output  16  write data to RAM
- ram_load  output  1  RAM write strobe; one-cycle pulse per word
- ram_address  output  ADDR_W  RAM address
- cpu_reset  output  1  high = CPU held in reset
- busy  output  1  load in progress
- done  output  1  load completed successfully (level)
- error  output  1  load failed (level)
- words_written  output  16  count of words written in the current/last load

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE, ram_in=0, ram_load=0, ram_address=BASE_ADDR, cpu_reset=1, busy=0, done=0, error=0, words_written=0, all internal counters 0.
- States: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, [CSUM_HI, CSUM_LO], DONE, ERROR.
- IDLE/DONE/ERROR + start:
  - Go to LEN_HI; busy=1, done=0, error=0, cpu_reset=1.
  - words_written=0; address pointer=BASE_ADDR; timeout counter=0.
- Start handling: start is ignored in all other states. Only the cycle start is seen is consumed; rx_valid in that same cycle is ignored.
- LEN_HI: on rx_valid, latch N[15:8], go to LEN_LO.
- LEN_LO: on rx_valid, latch N[7:0]. Then:
  - N > MAX_WORDS -> ERROR.
  - N == 0 -> DONE (or CSUM_HI with the feature).
  - otherwise -> DATA_HI.
- DATA_HI: on rx_valid, latch the high byte, go to DATA_LO.
- DATA_LO: on rx_valid:
  - On the next clock edge: ram_in={hi,rx_data}, ram_address=pointer, ram_load=1 for exactly one cycle. Latency is 1 cycle from the low-byte acceptance edge.
  - Pointer increments, wrapping at 2^ADDR_W; words_written increments.
  - If words_written reaches N -> DONE (or CSUM_HI), else -> DATA_HI.
- ram_load is never high in consecutive cycles. ram_address and ram_in hold their last values when ram_load=0.
- DONE: busy=0, done=1. cpu_reset=0 from the cycle after the final write strobe.
- ERROR: busy=0, error=1, cpu_reset=1. Further rx_valid bytes are ignored.
- Bytes arriving in IDLE, DONE or ERROR are dropped silently.
- Timeout:
  - In any state from LEN_HI through CSUM_LO, the counter increments each cycle without rx_valid and clears on rx_valid.
  - Reaching TIMEOUT_CYCLES -> ERROR. Words already written remain in RAM.
- reset_n asserted mid-load: immediate return to reset values. RAM contents are not touched.

Optional Feature:
- Macro: HACK_RAM_LOADER_CHECKSUM_EN.
- Defined:
  - A running 16-bit sum (mod 2^16) of all data words is kept.
  - After the last data word (or right after LEN_LO when N==0), two more bytes (CSUM_HI, CSUM_LO) form the expected checksum.
  - Match -> DONE. Mismatch -> ERROR.
  - Timeout applies to these bytes.
- Not defined: CSUM states and the summing logic are absent; the last data word goes directly to DONE.

Test Plan:
- Reset then idle: outputs are ram_load=0, cpu_reset=1, done=0, error=0, ram_address=0. Then send start + bytes 00 02 12 34 AB CD. Required: a write of 0x1234 @0 and a write of 0xABCD @1, one-cycle strobes; done=1, cpu_reset=0, words_written=2.
- start + bytes 00 00: DONE with no ram_load pulse. With the feature, append 00 00 for DONE; append 00 01 for ERROR.
- start + bytes 80 01 (N=32769): ERROR, no writes, cpu_reset stays 1. Subsequent data bytes produce no writes.
- BASE_ADDR=32767, N=2, words 0001 0002: writes land at 32767 then 0 (wrap); done=1.
- TIMEOUT_CYCLES=16, start + 00 03 11 22, then silence: error asserts exactly 16 cycles after the last byte. Word 0x1122 @0 was written. cpu_reset=1.
- Mid-load reset_n pulse after 1 of 3 words: all outputs return to reset values immediately. A new start + full stream then completes normally. Feature build: bytes 00 02 00 01 00 02 00 03 -> DONE; same stream with checksum 00 04 -> ERROR.
